// File: rtl/hazard_scoreboard.sv
// Hazard controller between ID and EX: tracks in-flight destinations, picks forwarding
// sources, raises load-use stalls and squashes issue slots after an EX redirect.
module hazard_scoreboard #(
    parameter int XLEN         = 32,
    parameter int FWD_STAGES   = 3,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    localparam int SELW        = $clog2(FWD_STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_vld,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_vld,
    input  logic            id_rs2_vld,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_vld,
    input  logic            id_is_load,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_addr,
    output logic            hold_if,
    output logic            issue_vld,
    output logic            redirect_vld,
    output logic [XLEN-1:0] redirect_addr,
    output logic [SELW-1:0] fwd_sel_rs1,
    output logic [SELW-1:0] fwd_sel_rs2,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    typedef enum logic {RUN, FLUSH} state_e;

    logic [FWD_STAGES-1:0] entVld_q;
    logic [FWD_STAGES-1:0] entLd_q;
    logic [4:0]            entRd_q [FWD_STAGES];

    state_e          state_q, state_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     stallCnt_q;
    logic [31:0]     flushCnt_q;

    logic            notReady1, notReady2;
    logic            stall;
    logic            stallSlot;
    logic            squashSlot;

    // Youngest matching entry wins; a load that has not reached LOAD_LAT yet cannot forward.
    always_comb begin
        logic found1, found2;
        found1      = 1'b0;
        found2      = 1'b0;
        notReady1   = 1'b0;
        notReady2   = 1'b0;
        fwd_sel_rs1 = '0;
        fwd_sel_rs2 = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            if (!found1 && entVld_q[k] && id_rs1_vld && (id_rs1 != 5'd0) && (entRd_q[k] == id_rs1)) begin
                found1 = 1'b1;
                if (!entLd_q[k] || (k >= LOAD_LAT)) fwd_sel_rs1 = SELW'(k + 1);
                else                                notReady1   = 1'b1;
            end
            if (!found2 && entVld_q[k] && id_rs2_vld && (id_rs2 != 5'd0) && (entRd_q[k] == id_rs2)) begin
                found2 = 1'b1;
                if (!entLd_q[k] || (k >= LOAD_LAT)) fwd_sel_rs2 = SELW'(k + 1);
                else                                notReady2   = 1'b1;
            end
        end
    end

    assign stall      = id_vld && (notReady1 || notReady2);
    assign stallSlot  = rst && !ex_redirect && (state_q != FLUSH) && stall;
    assign squashSlot = rst && id_vld && (ex_redirect || (state_q == FLUSH));

    // Outputs are forced low while reset is asserted so a reset mid-flush is visible at once.
    always_comb begin
        hold_if       = 1'b0;
        issue_vld     = 1'b0;
        redirect_vld  = 1'b0;
        redirect_addr = '0;
        if (rst) begin
            redirect_addr = addr_q;
            if (ex_redirect) begin
                redirect_vld  = 1'b1;
                redirect_addr = ex_redirect_addr;
            end else if (state_q == FLUSH) begin
                issue_vld = 1'b0;
            end else if (stall) begin
                hold_if = 1'b1;
            end else begin
                issue_vld = id_vld;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (ex_redirect) begin
            state_d = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
            fcnt_d  = 4'(FLUSH_CYCLES);
        end else if (state_q == FLUSH) begin
            fcnt_d = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            addr_q     <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (ex_redirect) addr_q <= ex_redirect_addr;
            if (stallSlot && (stallCnt_q != 32'hFFFF_FFFF)) stallCnt_q <= stallCnt_q + 32'd1;
            if (squashSlot && (flushCnt_q != 32'hFFFF_FFFF)) flushCnt_q <= flushCnt_q + 32'd1;
        end
    end

    // Destination pipe advances every cycle; a bubble enters entry0 when nothing issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entVld_q <= '0;
            entLd_q  <= '0;
            for (int k = 0; k < FWD_STAGES; k++) entRd_q[k] <= '0;
        end else begin
            for (int k = FWD_STAGES - 1; k > 0; k--) begin
                entVld_q[k] <= entVld_q[k-1];
                entLd_q[k]  <= entLd_q[k-1];
                entRd_q[k]  <= entRd_q[k-1];
            end
            entVld_q[0] <= issue_vld && id_rd_vld && (id_rd != 5'd0);
            entLd_q[0]  <= id_is_load;
            entRd_q[0]  <= id_rd;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard; a history-based reference model
// pushes expected outputs per cycle and a monitor process compares them.
module tb_hazard_scoreboard;

    localparam int XLEN         = 32;
    localparam int FWD_STAGES   = 3;
    localparam int LOAD_LAT     = 1;
    localparam int FLUSH_CYCLES = 3;
    localparam int SELW         = $clog2(FWD_STAGES + 1);

    logic            clk;
    logic            rst;
    logic            id_vld;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rs1_vld, id_rs2_vld, id_rd_vld, id_is_load;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_redirect_addr;
    logic            hold_if, issue_vld, redirect_vld;
    logic [XLEN-1:0] redirect_addr;
    logic [SELW-1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [31:0]     stall_cnt, flush_cnt;

    hazard_scoreboard #(
        .XLEN(XLEN), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld),
        .id_rd(id_rd), .id_rd_vld(id_rd_vld), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .ex_redirect_addr(ex_redirect_addr),
        .hold_if(hold_if), .issue_vld(issue_vld), .redirect_vld(redirect_vld),
        .redirect_addr(redirect_addr), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic            hold;
        logic            issue;
        logic            rv;
        logic [XLEN-1:0] addr;
        logic [SELW-1:0] sel1;
        logic [SELW-1:0] sel2;
        logic [31:0]     sc;
        logic [31:0]     fc;
    } exp_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       ld;
    } slot_t;

    exp_t  expQ[$];
    slot_t hist[$];
    int    squashLeft;
    int    mStall, mFlush;
    logic [XLEN-1:0] lastAddr;
    int    checks = 0;
    int    errors = 0;
    bit    stimDone = 0;
    bit    monDone = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the last FWD_STAGES issue slots, youngest first.
    function automatic void modelReset();
        hist.delete();
        for (int k = 0; k < FWD_STAGES; k++) hist.push_back('0);
        squashLeft = 0;
        mStall     = 0;
        mFlush     = 0;
        lastAddr   = '0;
    endfunction

    function automatic void lookup(input logic [4:0] rs, input logic rsVld,
                                   output logic [SELW-1:0] sel, output logic notReady);
        sel      = '0;
        notReady = 1'b0;
        if (!rsVld || rs == 5'd0) return;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].vld && hist[k].rd == rs) begin
                if (hist[k].ld && k < LOAD_LAT) notReady = 1'b1;
                else                            sel = SELW'(k + 1);
                return;
            end
        end
    endfunction

    function automatic void modelStep();
        exp_t e;
        logic nr1, nr2, stall, inFlush;
        lookup(id_rs1, id_rs1_vld, e.sel1, nr1);
        lookup(id_rs2, id_rs2_vld, e.sel2, nr2);
        stall   = id_vld && (nr1 || nr2);
        inFlush = squashLeft > 0;
        e.hold  = 1'b0;
        e.issue = 1'b0;
        e.rv    = ex_redirect;
        e.addr  = ex_redirect ? ex_redirect_addr : lastAddr;
        e.sc    = mStall;
        e.fc    = mFlush;
        if (!ex_redirect && !inFlush) begin
            if (stall) e.hold = 1'b1;
            else       e.issue = id_vld;
        end
        expQ.push_back(e);
        if (e.hold) mStall++;
        if (id_vld && (ex_redirect || inFlush)) mFlush++;
        if (ex_redirect) begin
            squashLeft = FLUSH_CYCLES;
            lastAddr   = ex_redirect_addr;
        end else if (squashLeft > 0) begin
            squashLeft--;
        end
        hist.push_front('{vld: e.issue && id_rd_vld && id_rd != 5'd0, rd: id_rd, ld: id_is_load});
        void'(hist.pop_back());
    endfunction

    task automatic applyStimulus(input logic vld, input logic [4:0] rs1, input logic r1v,
                                 input logic [4:0] rs2, input logic r2v,
                                 input logic [4:0] rd, input logic rdv, input logic ld,
                                 input logic redir, input logic [XLEN-1:0] addr);
        @(negedge clk);
        rst              = 1'b1;
        id_vld           = vld;
        id_rs1           = rs1;
        id_rs1_vld       = r1v;
        id_rs2           = rs2;
        id_rs2_vld       = r2v;
        id_rd            = rd;
        id_rd_vld        = rdv;
        id_is_load       = ld;
        ex_redirect      = redir;
        ex_redirect_addr = addr;
        modelStep();
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst              = 1'b0;
            id_vld           = 1'b1;
            ex_redirect      = $urandom_range(0, 1) == 1;
            ex_redirect_addr = $urandom;
            modelReset();
            expQ.push_back('0);
        end
    endtask

    task automatic randomCycle();
        logic [4:0] r1, r2, rd;
        r1 = 5'($urandom_range(0, 4));
        r2 = 5'($urandom_range(0, 4));
        rd = 5'($urandom_range(0, 4));
        applyStimulus($urandom_range(0, 9) < 8, r1, $urandom_range(0, 3) != 0,
                      r2, $urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, $urandom);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per presented cycle and compares every output.
    initial begin
        exp_t e;
        int   guard = 0;
        forever begin
            @(negedge clk);
            #3;
            guard++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("hold_if", 32'(hold_if), 32'(e.hold));
                checkOutput("issue_vld", 32'(issue_vld), 32'(e.issue));
                checkOutput("redirect_vld", 32'(redirect_vld), 32'(e.rv));
                checkOutput("redirect_addr", redirect_addr, e.addr);
                checkOutput("fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(e.sel1));
                checkOutput("fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(e.sel2));
                checkOutput("stall_cnt", stall_cnt, e.sc);
                checkOutput("flush_cnt", flush_cnt, e.fc);
            end else if (stimDone || guard > 20000) begin
                break;
            end
        end
        monDone = 1;
    end

    initial begin
        int waitCycles;
        rst = 1'b0; id_vld = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_vld = 1'b0; id_rs2_vld = 1'b0;
        id_rd = '0; id_rd_vld = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0; ex_redirect_addr = '0;
        modelReset();
        doReset(2);

        // ALU RAW, then load-use with one-cycle stall, then youngest-wins and x0 writes.
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        applyStimulus(1, 7, 1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);

        // Redirect during a load-use stall, then a second redirect inside the flush window.
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 1, 32'h100);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted mid-flush, then first valid instruction issues.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300);
        doReset(1);
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);

        for (int i = 0; i < 1500; i++) randomCycle();
        applyStimulus(1, 1, 1, 2, 1, 3, 1, 1, 1, 32'hABCD);
        doReset(2);
        for (int i = 0; i < 1500; i++) randomCycle();

        @(negedge clk);
        stimDone = 1;
        waitCycles = 0;
        while (!monDone && waitCycles < 100) begin
            @(posedge clk);
            waitCycles++;
        end
        if (!monDone) begin
            errors++;
            $display("[TB] FAIL monitor_timeout actual=%0d required=%0d", expQ.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
